// File: rtl/game_player_if.sv
// game_player_if: command handshake between a host sequencer (master) and game_player (slave).
// Signals: cmd_valid/cmd_ready handshake; cmd_load, cmd_value, cmd_control and cmd_repeat describe one move command.
interface game_player_if #(
  parameter int SIZE = 4
) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_load;
  logic [SIZE-1:0] cmd_value;
  logic [1:0]      cmd_control;
  logic [3:0]      cmd_repeat;
  modport master (output cmd_valid, cmd_load, cmd_value, cmd_control, cmd_repeat, input cmd_ready);
  modport slave  (input cmd_valid, cmd_load, cmd_value, cmd_control, cmd_repeat, output cmd_ready);
endinterface

// File: rtl/game_player.sv
// game_player: queues move commands and replays them onto the counter game, tracking match score.
// Ports: clk; reset (asynchronous, active-low); cmd (game_player_if.slave) command FIFO handshake;
// INIT_c/INIT_l/control drive the counter; WINNER/LOSER/GAMEOVER/WHO observe the game;
// busy/done/result report match state; rounds_won/rounds_lost mirror the score.
// Build option: define GAME_PLAYER_SCORE_EN to include the score counters (otherwise tied to 0).
module game_player #(
  parameter int SIZE      = 4,
  parameter int MAX_SCORE = 4,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  game_player_if.slave         cmd,
  output logic                 INIT_c,
  output logic [SIZE-1:0]      INIT_l,
  output logic [1:0]           control,
  input  logic                 WINNER,
  input  logic                 LOSER,
  input  logic                 GAMEOVER,
  input  logic [1:0]           WHO,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           result,
  output logic [MAX_SCORE-1:0] rounds_won,
  output logic [MAX_SCORE-1:0] rounds_lost
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = SIZE + 7;
  typedef enum logic [1:0] {IDLE, LOAD, DRIVE, HALT} state_e;
  state_e          state_q, state_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q;
  logic [W-1:0]    head;
  logic            go, push, pop, empty, full;
  logic [SIZE-1:0] value_q;
  logic [1:0]      ctrl_q;
  logic [3:0]      rem_q;
  logic            init_c_q, init_c_d;
  logic [SIZE-1:0] init_l_q, init_l_d;
  logic [1:0]      control_q, control_d;
  logic            done_q;
  logic [1:0]      result_q, result_d;
  // entry layout: {load, value, control, repeat}
  assign head  = mem_q[rd_q];
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  // a match end in any state but HALT overrides everything else this cycle
  assign go    = GAMEOVER && state_q != HALT;
  assign cmd.cmd_ready = !full && state_q != HALT;
  assign push  = cmd.cmd_valid && cmd.cmd_ready && !go;
  // the next command is taken from IDLE or on the last DRIVE cycle so commands chain without a bubble
  assign pop   = !go && !empty && (state_q == IDLE || (state_q == DRIVE && rem_q == '0));
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (go) state_d = HALT;
    else if (pop) state_d = head[W-1] ? LOAD : DRIVE;
    else if (state_q == LOAD) state_d = DRIVE;
    else if (state_q == DRIVE && rem_q == '0) state_d = IDLE;
    else if (state_q == HALT && !GAMEOVER) state_d = IDLE;
  end
  always_comb begin
    init_c_d  = !go && state_q == LOAD;
    init_l_d  = state_q == LOAD ? value_q : init_l_q;
    control_d = state_q == DRIVE ? ctrl_q : control_q;
    result_d  = go ? WHO : result_q;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {cmd.cmd_load, cmd.cmd_value, cmd.cmd_control, cmd.cmd_repeat};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (go) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      value_q <= '0;
      ctrl_q  <= '0;
      rem_q   <= '0;
    end else if (pop) begin
      value_q <= head[W-2 -: SIZE];
      ctrl_q  <= head[5:4];
      rem_q   <= head[3:0];
    end else if (state_q == DRIVE && rem_q != '0) begin
      rem_q <= rem_q - 4'd1;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      init_c_q  <= 1'b0;
      init_l_q  <= '0;
      control_q <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      init_c_q  <= init_c_d;
      init_l_q  <= init_l_d;
      control_q <= control_d;
      done_q    <= go;
      result_q  <= result_d;
    end
  assign INIT_c  = init_c_q;
  assign INIT_l  = init_l_q;
  assign control = control_q;
  assign done    = done_q;
  assign result  = result_q;
  assign busy    = state_q != IDLE;
`ifdef GAME_PLAYER_SCORE_EN
  logic [MAX_SCORE-1:0] won_q, lost_q;
  // a simultaneous WINNER/LOSER counts only as a win; both saturate at all-ones
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      won_q  <= '0;
      lost_q <= '0;
    end else if (go) begin
      won_q  <= '0;
      lost_q <= '0;
    end else begin
      won_q  <= won_q + MAX_SCORE'(WINNER && !(&won_q));
      lost_q <= lost_q + MAX_SCORE'(LOSER && !WINNER && !(&lost_q));
    end
  assign rounds_won  = won_q;
  assign rounds_lost = lost_q;
`else
  logic unused_score;
  assign unused_score = WINNER ^ LOSER;
  assign rounds_won   = {MAX_SCORE{1'b0}};
  assign rounds_lost  = {MAX_SCORE{1'b0}};
`endif
endmodule
